// File: rtl/gs_mem_pkg.sv
// Shared definitions for the General Sound DDRAM read cache.
// Contents: FSM state encoding, GS/DDRAM address widths, helpers that derive
// the line-index and tag widths from the line count, and a byte selector.
package gs_mem_pkg;

    localparam int GS_AW  = 21;
    localparam int DDR_AW = 29;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_FILL      = 3'd2,
        ST_FILL_WAIT = 3'd3,
        ST_WRITE     = 3'd4
    } state_t;

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int lines);
        return GS_AW - 3 - $clog2(lines);
    endfunction

    function automatic logic [7:0] sel_byte(input logic [63:0] word, input logic [2:0] sel);
        return word[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/gs_cache_ram.sv
// Simple-dual-port line store for the GS cache: {tag, 64-bit data} per line.
// Read port : raddr -> rtag/rdata, registered (1-cycle latency).
// Write port: we with per-byte enables be; tag_we also rewrites the tag
//             (line fill), tag_we=0 leaves the tag alone (write-hit update).
module gs_cache_ram #(
    parameter int IDX = 6,
    parameter int TW  = 12
) (
    input  logic           clk,
    input  logic [IDX-1:0] raddr,
    output logic [TW-1:0]  rtag,
    output logic [63:0]    rdata,
    input  logic           we,
    input  logic           tag_we,
    input  logic [IDX-1:0] waddr,
    input  logic [7:0]     be,
    input  logic [TW-1:0]  wtag,
    input  logic [63:0]    wdata
);

    localparam int DEPTH = 1 << IDX;

    logic [TW-1:0] tag_mem  [DEPTH];
    logic [63:0]   data_mem [DEPTH];

    // Write port: byte-enabled data update, optional tag rewrite.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) begin
                    data_mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            if (tag_we) begin
                tag_mem[waddr] <= wtag;
            end
        end
    end

    // Read port: registered tag and data.
    always_ff @(posedge clk) begin
        rtag  <= tag_mem[raddr];
        rdata <= data_mem[raddr];
    end

endmodule

// File: rtl/gs_mem_cache.sv
// Direct-mapped write-through read cache between the byte-wide GS memory port
// and the 64-bit single-beat DDRAM Avalon port.
// Core side : addr/din/rd/wr in, dout/ready out, flush pulse invalidates all.
// DDRAM side: DDRAM_RD/DDRAM_WE/DDRAM_ADDR/DDRAM_DIN/DDRAM_BE registered out,
//             DDRAM_BUSY (waitrequest), DDRAM_DOUT/DDRAM_DOUT_READY in.
module gs_mem_cache
    import gs_mem_pkg::*;
#(
    parameter int                LINES = 64,
    parameter logic [DDR_AW-1:0] BASE  = 29'h0700000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [GS_AW-1:0]  addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              rd,
    input  logic              wr,
    output logic              ready,
    input  logic              flush,
    input  logic              DDRAM_BUSY,
    output logic [7:0]        DDRAM_BURSTCNT,
    output logic [DDR_AW-1:0] DDRAM_ADDR,
    input  logic [63:0]       DDRAM_DOUT,
    input  logic              DDRAM_DOUT_READY,
    output logic              DDRAM_RD,
    output logic [63:0]       DDRAM_DIN,
    output logic [7:0]        DDRAM_BE,
    output logic              DDRAM_WE
);

    localparam int IDX = idx_width(LINES);
    localparam int TW  = tag_width(LINES);

    state_t            state_r, state_nxt;
    logic [GS_AW-1:0]  addr_r;
    logic              wr_r, prev_none_r;
    logic [LINES-1:0]  valid_r, valid_nxt;
    logic              flush_pend_r, flush_nxt;
    logic              ready_r, ready_nxt;
    logic [7:0]        dout_r, dout_nxt;
    logic              ddr_rd_r, ddr_rd_nxt, ddr_we_r, ddr_we_nxt;
    logic [DDR_AW-1:0] ddr_addr_r, ddr_addr_nxt;
    logic [63:0]       ddr_din_r, ddr_din_nxt;
    logic [7:0]        ddr_be_r, ddr_be_nxt;

    logic              req_s, accept_s, hit_s, done_s, fill_s;
    logic [IDX-1:0]    line_s, ram_raddr_s;
    logic [TW-1:0]     tag_s, ram_rtag_s;
    logic [63:0]       ram_rdata_s, ram_wdata_s;
    logic              ram_we_s, ram_tag_we_s;
    logic [7:0]        ram_be_s;

    assign line_s   = addr_r[3 +: IDX];
    assign tag_s    = addr_r[GS_AW-1 -: TW];
    assign req_s    = rd | wr;
    // A held request is not re-accepted; only a fresh edge or a change of address/type is.
    assign accept_s = (state_r == ST_IDLE) && req_s &&
                      (prev_none_r || (addr != addr_r) || (wr != wr_r));
    // In IDLE the RAM is read with the incoming address so the tag is ready in LOOKUP.
    assign ram_raddr_s = (state_r == ST_IDLE) ? addr[3 +: IDX] : line_s;
    assign hit_s    = valid_r[line_s] && (ram_rtag_s == tag_s);

    assign dout           = dout_r;
    assign ready          = ready_r;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = ddr_addr_r;
    assign DDRAM_RD       = ddr_rd_r;
    assign DDRAM_WE       = ddr_we_r;
    assign DDRAM_DIN      = ddr_din_r;
    assign DDRAM_BE       = ddr_be_r;

    gs_cache_ram #(.IDX(IDX), .TW(TW)) u_ram (
        .clk    (clk),
        .raddr  (ram_raddr_s),
        .rtag   (ram_rtag_s),
        .rdata  (ram_rdata_s),
        .we     (ram_we_s),
        .tag_we (ram_tag_we_s),
        .waddr  (line_s),
        .be     (ram_be_s),
        .wtag   (tag_s),
        .wdata  (ram_wdata_s)
    );

    // Next-state, registered-output and valid-vector computation.
    always_comb begin
        state_nxt    = state_r;
        ready_nxt    = ready_r;
        dout_nxt     = dout_r;
        ddr_rd_nxt   = ddr_rd_r;
        ddr_we_nxt   = ddr_we_r;
        ddr_addr_nxt = ddr_addr_r;
        ddr_din_nxt  = ddr_din_r;
        ddr_be_nxt   = ddr_be_r;
        valid_nxt    = valid_r;
        flush_nxt    = flush_pend_r;
        ram_we_s     = 1'b0;
        ram_tag_we_s = 1'b0;
        ram_be_s     = 8'h00;
        ram_wdata_s  = 64'h0;
        done_s       = 1'b0;
        fill_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    ready_nxt    = 1'b0;
                    ddr_addr_nxt = BASE + {{(DDR_AW-GS_AW+3){1'b0}}, addr[GS_AW-1:3]};
                    ddr_be_nxt   = 8'd1 << addr[2:0];
                    if (wr) begin
                        state_nxt   = ST_WRITE;
                        ddr_we_nxt  = 1'b1;
                        ddr_din_nxt = {8{din}};
                    end else begin
                        state_nxt   = ST_LOOKUP;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (hit_s) begin
                    state_nxt = ST_IDLE;
                    ready_nxt = 1'b1;
                    dout_nxt  = sel_byte(ram_rdata_s, addr_r[2:0]);
                    done_s    = 1'b1;
                end else begin
                    state_nxt  = ST_FILL;
                    ddr_rd_nxt = 1'b1;
                end
            end
            ST_FILL: begin
                if (!DDRAM_BUSY) begin
                    state_nxt  = ST_FILL_WAIT;
                    ddr_rd_nxt = 1'b0;
                end else begin
                    state_nxt  = ST_FILL;
                end
            end
            ST_FILL_WAIT: begin
                if (DDRAM_DOUT_READY) begin
                    state_nxt    = ST_IDLE;
                    ready_nxt    = 1'b1;
                    dout_nxt     = sel_byte(DDRAM_DOUT, addr_r[2:0]);
                    ram_we_s     = 1'b1;
                    ram_tag_we_s = 1'b1;
                    ram_be_s     = 8'hFF;
                    ram_wdata_s  = DDRAM_DOUT;
                    done_s       = 1'b1;
                    fill_s       = 1'b1;
                end else begin
                    state_nxt    = ST_FILL_WAIT;
                end
            end
            ST_WRITE: begin
                if (!DDRAM_BUSY) begin
                    state_nxt  = ST_IDLE;
                    ready_nxt  = 1'b1;
                    ddr_we_nxt = 1'b0;
                    done_s     = 1'b1;
                    // Write-through without allocate: only a resident line is patched.
                    if (hit_s) begin
                        ram_we_s    = 1'b1;
                        ram_be_s    = ddr_be_r;
                        ram_wdata_s = ddr_din_r;
                    end else begin
                        ram_we_s    = 1'b0;
                    end
                end else begin
                    state_nxt  = ST_WRITE;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                ready_nxt  = 1'b1;
                ddr_rd_nxt = 1'b0;
                ddr_we_nxt = 1'b0;
            end
        endcase

        // Flush acts at once in IDLE; otherwise it waits for the return to IDLE,
        // and a fill finishing under a pending flush leaves its line invalid.
        if (state_r == ST_IDLE) begin
            flush_nxt = 1'b0;
            if (flush) begin
                valid_nxt = {LINES{1'b0}};
            end else begin
                valid_nxt = valid_r;
            end
        end else if (done_s) begin
            flush_nxt = 1'b0;
            if (flush_pend_r || flush) begin
                valid_nxt = {LINES{1'b0}};
            end else if (fill_s) begin
                valid_nxt[line_s] = 1'b1;
            end else begin
                valid_nxt = valid_r;
            end
        end else begin
            flush_nxt = flush_pend_r | flush;
            valid_nxt = valid_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Datapath, request tracking, valid vector and DDRAM command registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_r       <= {GS_AW{1'b0}};
            wr_r         <= 1'b0;
            prev_none_r  <= 1'b1;
            valid_r      <= {LINES{1'b0}};
            flush_pend_r <= 1'b0;
            ready_r      <= 1'b1;
            dout_r       <= 8'h00;
            ddr_rd_r     <= 1'b0;
            ddr_we_r     <= 1'b0;
            ddr_addr_r   <= {DDR_AW{1'b0}};
            ddr_din_r    <= 64'h0;
            ddr_be_r     <= 8'h00;
        end else begin
            prev_none_r  <= ~req_s;
            if (accept_s) begin
                addr_r <= addr;
                wr_r   <= wr;
            end
            valid_r      <= valid_nxt;
            flush_pend_r <= flush_nxt;
            ready_r      <= ready_nxt;
            dout_r       <= dout_nxt;
            ddr_rd_r     <= ddr_rd_nxt;
            ddr_we_r     <= ddr_we_nxt;
            ddr_addr_r   <= ddr_addr_nxt;
            ddr_din_r    <= ddr_din_nxt;
            ddr_be_r     <= ddr_be_nxt;
        end
    end

endmodule

// File: tb/tb_gs_mem_cache.sv
// Directed bench for gs_mem_cache: a DDRAM bus model with programmable
// waitrequest and read latency, a cache-residency model (which word each
// line holds), per-cycle bus protocol checks and per-transaction result checks.
`timescale 1ns/1ps
module tb_gs_mem_cache;

    localparam int          LINES = 64;
    localparam logic [28:0] BASE  = 29'h0700000;

    logic        clk = 1'b0;
    logic        reset_n, rd, wr, flush;
    logic [20:0] addr;
    logic [7:0]  din, dout;
    logic        ready;
    logic        DDRAM_BUSY, DDRAM_DOUT_READY, DDRAM_RD, DDRAM_WE;
    logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT, DDRAM_DIN;

    always #5 clk = ~clk;

    gs_mem_cache #(.LINES(LINES), .BASE(BASE)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
        .rd(rd), .wr(wr), .ready(ready), .flush(flush),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
        .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(DDRAM_DOUT),
        .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD),
        .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
    );

    int vectors = 0, miscompares = 0;

    logic [63:0] mem [logic [28:0]];
    int          line_word [LINES];

    logic [20:0] cur_addr = 21'h0;
    logic [7:0]  cur_din  = 8'h00;
    int          busy_hold = 0, busy_seen = 0, rd_cmds = 0, we_cmds = 0;
    int          resp_cnt = 0, resp_lat = 3;
    logic [28:0] resp_addr = 29'h0, last_rd_addr = 29'h0;
    logic [7:0]  last_we_be = 8'h00;
    logic [63:0] last_we_din = 64'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input logic [28:0] w);
        if (mem.exists(w)) return mem[w];
        else return {8{w[7:0]}} ^ 64'h0123456789ABCDEF;
    endfunction

    function automatic logic [28:0] word_addr(input logic [20:0] a);
        return BASE + {11'd0, a[20:3]};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [20:0] a);
        logic [63:0] w;
        w = word_of(word_addr(a));
        return w[a[2:0]*8 +: 8];
    endfunction

    task automatic model_flush();
        for (int i = 0; i < LINES; i++) line_word[i] = -1;
    endtask

    // DDRAM bus model plus per-cycle protocol checks.
    logic        prev_cmd = 1'b0, prev_rd = 1'b0, prev_we = 1'b0;
    logic [28:0] prev_addr = 29'h0;
    logic [63:0] prev_din = 64'h0;
    logic [7:0]  prev_be = 8'h00;

    initial begin
        logic [28:0] wa;
        logic [63:0] tmp;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT_READY = 1'b0; DDRAM_DOUT = 64'h0;
        forever begin
            @(negedge clk);
            DDRAM_DOUT_READY = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    DDRAM_DOUT_READY = 1'b1;
                    DDRAM_DOUT       = word_of(resp_addr);
                end
            end
            if (reset_n) begin
                chk("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
                chk("rd_we_exclusive", 64'(DDRAM_RD & DDRAM_WE), 64'd0);
                if (prev_cmd && DDRAM_BUSY) begin
                    chk("hold_rd", 64'(DDRAM_RD), 64'(prev_rd));
                    chk("hold_we", 64'(DDRAM_WE), 64'(prev_we));
                    chk("hold_addr", 64'(DDRAM_ADDR), 64'(prev_addr));
                    chk("hold_din", DDRAM_DIN, prev_din);
                    chk("hold_be", 64'(DDRAM_BE), 64'(prev_be));
                end
                if (DDRAM_RD || DDRAM_WE) begin
                    chk("cmd_addr", 64'(DDRAM_ADDR), 64'(word_addr(cur_addr)));
                    chk("cmd_be", 64'(DDRAM_BE), 64'(8'd1 << cur_addr[2:0]));
                    chk("cmd_ready_low", 64'(ready), 64'd0);
                end
                if (DDRAM_WE) chk("cmd_din", DDRAM_DIN, {8{cur_din}});
            end
            prev_cmd  = reset_n && (DDRAM_RD || DDRAM_WE);
            prev_rd   = DDRAM_RD;
            prev_we   = DDRAM_WE;
            prev_addr = DDRAM_ADDR;
            prev_din  = DDRAM_DIN;
            prev_be   = DDRAM_BE;
            if (reset_n && (DDRAM_RD || DDRAM_WE)) begin
                if (busy_hold > 0) begin
                    DDRAM_BUSY = 1'b1;
                    busy_hold--;
                    busy_seen++;
                end else begin
                    DDRAM_BUSY = 1'b0;
                    if (DDRAM_RD) begin
                        rd_cmds++;
                        last_rd_addr = DDRAM_ADDR;
                        resp_addr    = DDRAM_ADDR;
                        resp_cnt     = resp_lat;
                    end else begin
                        we_cmds++;
                        last_we_be  = DDRAM_BE;
                        last_we_din = DDRAM_DIN;
                        wa  = word_addr(cur_addr);
                        tmp = word_of(wa);
                        tmp[cur_addr[2:0]*8 +: 8] = cur_din;
                        mem[wa] = tmp;
                    end
                end
            end else begin
                DDRAM_BUSY = 1'b0;
            end
        end
    end

    task automatic do_read(input logic [20:0] a, input bit flush_mid, input string nm);
        logic [7:0] expb;
        bit         exp_hit, flushed;
        int         rd0, idx;
        expb    = exp_byte(a);
        idx     = int'(a[8:3]);
        exp_hit = (line_word[idx] == int'(a[20:3]));
        rd0     = rd_cmds;
        cur_addr = a;
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk({nm, " busy"}, 64'(ready), 64'd0);
        @(negedge clk);
        if (exp_hit) chk({nm, " hit_ready_n2"}, 64'(ready), 64'd1);
        flushed = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (ready) break;
            if (flush_mid && !flushed && rd_cmds != rd0) begin
                flush = 1'b1; flushed = 1'b1;
            end else begin
                flush = 1'b0;
            end
            @(negedge clk);
        end
        flush = 1'b0;
        chk({nm, " done"}, 64'(ready), 64'd1);
        chk({nm, " dout"}, 64'(dout), 64'(expb));
        chk({nm, " ddr_reads"}, 64'(rd_cmds - rd0), exp_hit ? 64'd0 : 64'd1);
        if (flush_mid) chk({nm, " flush_sent"}, 64'(flushed), 64'd1);
        if (flushed) model_flush();
        else if (!exp_hit) line_word[idx] = int'(a[20:3]);
    endtask

    task automatic do_write(input logic [20:0] a, input logic [7:0] d, input string nm);
        int rd0, we0;
        rd0 = rd_cmds; we0 = we_cmds;
        cur_addr = a; cur_din = d;
        addr = a; din = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        chk({nm, " busy"}, 64'(ready), 64'd0);
        for (int c = 0; c < 64; c++) begin
            if (ready) break;
            @(negedge clk);
        end
        chk({nm, " done"}, 64'(ready), 64'd1);
        chk({nm, " ddr_writes"}, 64'(we_cmds - we0), 64'd1);
        chk({nm, " ddr_reads"}, 64'(rd_cmds - rd0), 64'd0);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, " ready"}, 64'(ready), 64'd1);
        chk({nm, " dout"}, 64'(dout), 64'd0);
        chk({nm, " ddram_rd"}, 64'(DDRAM_RD), 64'd0);
        chk({nm, " ddram_we"}, 64'(DDRAM_WE), 64'd0);
        chk({nm, " ddram_be"}, 64'(DDRAM_BE), 64'd0);
    endtask

    initial begin
        int rd0, bs0;
        reset_n = 1'b0; rd = 1'b0; wr = 1'b0; flush = 1'b0; addr = 21'h0; din = 8'h00;
        model_flush();
        mem[BASE] = 64'h8877665544332211;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        chk("reset burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
        reset_n = 1'b1;
        @(negedge clk);

        do_read(21'h00005, 1'b0, "rd5_miss");
        chk("lit rd5 dout", 64'(dout), 64'h66);
        chk("lit rd5 addr", 64'(last_rd_addr), 64'h0700000);
        do_read(21'h00003, 1'b0, "rd3_hit");
        chk("lit rd3 dout", 64'(dout), 64'h44);

        do_write(21'h00003, 8'h55, "wr3_hit");
        chk("lit wr3 be", 64'(last_we_be), 64'h08);
        chk("lit wr3 din", last_we_din, 64'h5555555555555555);
        do_read(21'h00003, 1'b0, "rd3_after_wr");
        chk("lit rd3 updated", 64'(dout), 64'h55);

        do_read(21'h00008, 1'b0, "rd8_miss");
        chk("lit rd8 addr", 64'(last_rd_addr), 64'h0700001);
        do_read(21'h00208, 1'b0, "rd208_conflict");
        chk("lit rd208 addr", 64'(last_rd_addr), 64'h0700041);
        do_read(21'h00008, 1'b0, "rd8_evicted");

        busy_hold = 5; bs0 = busy_seen;
        do_read(21'h00030, 1'b0, "rd30_busy");
        chk("busy cycles", 64'(busy_seen - bs0), 64'd5);

        do_write(21'h00100, 8'hA7, "wr100_miss");
        do_read(21'h00100, 1'b0, "rd100_no_alloc");
        chk("lit rd100 dout", 64'(dout), 64'hA7);

        do_read(21'h00028, 1'b0, "rd28_fill");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_flush();
        do_read(21'h00028, 1'b0, "rd28_after_idle_flush");

        resp_lat = 5;
        do_read(21'h00010, 1'b1, "rd10_flush_mid");
        resp_lat = 3;
        do_read(21'h00010, 1'b0, "rd10_refetch");
        do_read(21'h00005, 1'b0, "rd5_after_flush");

        resp_lat = 8; rd0 = rd_cmds;
        cur_addr = 21'h00018; addr = 21'h00018; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (rd_cmds != rd0) break;
            @(negedge clk);
        end
        chk("rstmid fill_issued", 64'(rd_cmds - rd0), 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk_reset_state("rstmid");
        for (int c = 0; c < 20; c++) begin
            if (resp_cnt == 0) break;
            @(negedge clk);
        end
        chk("rstmid resp_delivered", 64'(resp_cnt), 64'd0);
        repeat (2) @(negedge clk);
        chk("rstmid ready_after_resp", 64'(ready), 64'd1);
        chk("rstmid dout_after_resp", 64'(dout), 64'd0);
        model_flush();
        resp_lat = 3;
        do_read(21'h00018, 1'b0, "rd18_after_reset");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gs_mem_cache.md
# gs_mem_cache

Direct-mapped, write-through read cache between the General Sound memory port of the `tsconf` core and the 64-bit DDRAM Avalon port. It presents the byte-wide GS interface (`addr`/`din`/`dout`/`rd`/`wr`/`ready`) to the core and issues single-beat 64-bit DDRAM transactions. Its purpose is to hide DDRAM latency on sequential GS sample and code fetches. Capacity masking (512K/1M/2M) stays outside the block, on `dout`.

## Interface
- `LINES`, default 64: number of cache lines (power of 2); index = `addr[3+IDX-1:3]`, where IDX = log2(LINES).
- `BASE`, default 29'h0700000: DDRAM 64-bit word address of GS byte 0.
- `clk` in 1: system clock (clk_sys); all logic on its rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `addr` in 21: GS byte address.
- `din` in 8: write data.
- `dout` out 8: read data; valid while `ready`=1 after a read.
- `rd` in 1: read request (level).
- `wr` in 1: write request (level).
- `ready` out 1: 1 = idle/complete, 0 = busy.
- `flush` in 1: one-cycle pulse; invalidates all lines.
- `DDRAM_BUSY` in 1: Avalon waitrequest.
- `DDRAM_BURSTCNT` out 8: constant 1.
- `DDRAM_ADDR` out 29: `BASE + addr[20:3]`.
- `DDRAM_DOUT` in 64: read data.
- `DDRAM_DOUT_READY` in 1: read data valid.
- `DDRAM_RD` out 1: read command.
- `DDRAM_DIN` out 64: `din` replicated ×8.
- `DDRAM_BE` out 8: one-hot `1<<addr[2:0]`.
- `DDRAM_WE` out 1: write command.

## Operation
- Request detection: a request is accepted in IDLE when (`rd`|`wr`) is 1 and either the previous cycle had `rd`=`wr`=0, or `addr` or the rd/wr type differs from the last accepted request. Accept latches `addr`, `din`, and the type. `wr` wins if both are set.
- States:
  - IDLE
  - LOOKUP: read tag/valid/data, 1 cycle.
  - FILL: `DDRAM_RD` held until `!DDRAM_BUSY`.
  - FILL_WAIT: wait for `DDRAM_DOUT_READY`.
  - WRITE: `DDRAM_WE` held until `!DDRAM_BUSY`.
- Read hit (valid && tag == `addr[20:3+IDX]`): LOOKUP→IDLE; `dout` = line byte `addr[2:0]`.
- Read miss: LOOKUP→FILL→FILL_WAIT. On `DDRAM_DOUT_READY`, write the line, set its tag and valid bit, drive the selected byte on `dout`, and go to IDLE.
- Write: IDLE→WRITE. If the line hits, update only that byte in the cached line (no allocate on miss). Return to IDLE when the command is accepted.
- Valid bits: register vector of width LINES. Tags and data are an inferred simple-dual-port RAM with 1-cycle read latency.
- `flush`:
  - In IDLE: clears all valid bits that cycle.
  - Otherwise: latched, and applied on the cycle the block returns to IDLE. A fill in progress still returns data to the core but does not mark its line valid.
- Address arithmetic: `DDRAM_ADDR` is a 29-bit modulo sum; no bounds check.

## Timing
- Reset (`reset_n`=0 at an edge): state IDLE; all valid bits 0; `ready`=1; `dout`=0; `DDRAM_RD`=`DDRAM_WE`=0; `DDRAM_BE`=0; pending flush cleared. Reset mid-fill abandons the transaction: the next DDRAM_DOUT_READY pulse is ignored because the state is IDLE.
- `ready` falls the cycle after accept, so the core sees 0 no later than edge +1.
- Read hit: accept at edge N; `ready`=1 with valid `dout` at edge N+2.
- Read miss: `ready`=1 and `dout` valid one cycle after the `DDRAM_DOUT_READY` cycle.
- Write: `ready`=1 one cycle after the cycle with `DDRAM_WE`=1 && `!DDRAM_BUSY`.
- `DDRAM_RD`/`DDRAM_WE` are registered and held stable, with stable address/data, while `DDRAM_BUSY`=1.
- At most one DDRAM transaction is outstanding.
- `dout` holds its last value until the next read completes.

## Structure
- Shared package `gs_mem_pkg`:
  - state enum
  - `GS_AW`=21
  - `DDR_AW`=29
  - line/tag width functions derived from LINES
- One sub-module, `gs_cache_ram`: simple-dual-port RAM holding {tag, 64-bit data}, with byte-enable write for write-hit updates.
- Everything else (FSM, valid vector, request detect) lives in `gs_mem_cache`.

## Test plan
- After reset, read 0x00005 (BASE word holds 64'h8877665544332211): `DDRAM_RD` with `DDRAM_ADDR`=BASE → `dout`=0x66. Re-read 0x00003: no DDRAM_RD, `dout`=0x44 at N+2.
- Write 0x55 to 0x00003 after that fill → `DDRAM_WE`, `DDRAM_BE`=8'h08, `DDRAM_DIN`=64'h5555…55. Re-read 0x00003 hits → 0x55.
- Read 0x00008 then 0x00208 (same index, different tag, LINES=64) → two fills, `DDRAM_ADDR`=BASE+1 then BASE+0x41. Re-read 0x00008 → miss again.
- Hold `DDRAM_BUSY`=1 for 5 cycles during a fill → `DDRAM_RD` and `DDRAM_ADDR` stable all 5 cycles, single command issued, `ready`=0 throughout.
- Pulse `flush` during FILL_WAIT → correct byte returned. A subsequent read of the same address and any previously cached address both miss.
- Assert `reset_n`=0 during FILL_WAIT, then deliver `DDRAM_DOUT_READY` → ignored; `ready`=1; the next read of that address misses.
